relay_sched: RTL and testbench
==============================

RELAY_SCHED -- requirements
Module: relay_sched

Interface
REQ-001 SHALL have ports: ck_1356meg  in  1  13.56 MHz clock, sole clock domain.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: cmd_valid  in  1  command strobe from ARM config path.
REQ-004 SHALL have: cmd_op  in  2  00 nop, 01 run-master, 10 run-slave, 11 abort.
REQ-005 SHALL have: timeout_cfg  in  16  window length in ticks; 0 = no timeout.
REQ-006 SHALL have: data_in  in  1  relay link line from peer Proxmark (asynchronous).
REQ-007 SHALL have: mod_type  out  3  relay mode select; 000 MASTER, 001 SLAVE, 010 DELAY.
REQ-008 SHALL have: cmd_ready  out  1  high only in IDLE.
REQ-009 SHALL have: busy  out  1  high in any state other than IDLE.
REQ-010 SHALL have: done  out  1  one-cycle pulse on normal completion.
REQ-011 SHALL have: timed_out  out  1  one-cycle pulse on timeout exit.

Function
REQ-012 SHALL generate tick = 1-cycle pulse when free-running 3-bit divider equals 3'b100 (1.695 MHz); all window counting in ticks.
REQ-013 SHALL synchronise data_in through 2 flops; edge = sync rising edge, evaluated every clock.
REQ-014 SHALL implement states IDLE, MASTER_RUN, REPORT, SLAVE_RUN.
REQ-015 SHALL accept non-abort command when cmd_valid & cmd_ready; nop ignored; state changes on next clock.
REQ-016 SHALL latch timeout_cfg into 16-bit tick counter base on command accept; later changes ignored until next accept.
REQ-017 IDLE: mod_type = 001 (SLAVE, passive listen).
REQ-018 run-master: IDLE -> MASTER_RUN, mod_type = 000 from first cycle in state, tick counter cleared.
REQ-019 MASTER_RUN: sync edge on data_in -> REPORT next cycle.
REQ-020 MASTER_RUN: tick counter reaching latched timeout (non-zero) -> IDLE, timed_out pulse.
REQ-021 MASTER_RUN: edge and timeout in same cycle -> edge wins (REPORT, no timed_out).
REQ-022 REPORT: mod_type = 010; count ticks to REPORT_TICKS (65 552, 17-bit); at terminal count -> IDLE, done pulse.
REQ-023 run-slave: IDLE -> SLAVE_RUN, mod_type = 001; latched timeout 0 -> stay until abort; else at terminal count -> IDLE, done pulse.
REQ-024 abort SHALL be accepted in any state regardless of cmd_ready: next cycle IDLE, mod_type 001, counters cleared, no done/timed_out.
REQ-025 abort SHALL take priority over edge, timeout and terminal count in same cycle.
REQ-026 Abort in IDLE SHALL be a no-op.
REQ-027 Tick counter SHALL saturate, never wrap; terminal compare is equality at tick.
REQ-028 done and timed_out SHALL never assert in same cycle; pulses registered.

Reset
REQ-029 On rst_n low: state IDLE, mod_type 001, cmd_ready 1, busy 0, done 0, timed_out 0, divider, counters, synchroniser 0.
REQ-030 Reset mid-operation SHALL abandon window without any pulse; operation resumes from IDLE after release.

Structure
REQ-031 Shared package relay_pkg SHALL hold mod_type constants (MASTER/SLAVE/DELAY), cmd_op codes, state enum, REPORT_TICKS.
REQ-032 Tick divider SHALL be sub-module relay_tick_gen (clock, reset, tick out), reusable by relay.
REQ-033 All state SHALL be in ck_1356meg domain; no latches; no combinational path from data_in to outputs.

Verification
REQ-034 Reset release, no commands -> mod_type 001, cmd_ready 1, busy 0 held for 10 000 cycles.
REQ-035 run-master, timeout_cfg 100, data_in rises at tick 40 -> mod_type 000 then 010 within 3 cycles of edge; done exactly 65 552 ticks later; mod_type 001 after.
REQ-036 run-master, timeout_cfg 100, data_in static 0 -> timed_out pulse at tick 100, IDLE, no done.
REQ-037 run-slave, timeout_cfg 0, abort after 5 000 cycles -> IDLE next cycle, no done/timed_out; run-master while busy ignored.
REQ-038 MASTER_RUN, edge coincident with timeout tick -> REPORT, no timed_out; repeat with abort same cycle -> IDLE, no pulses.
REQ-039 rst_n asserted mid-REPORT -> immediate mod_type 001, counters 0, no done after release.

Source files
------------

// File: rtl/relay_pkg.sv
// rtl/relay_pkg.sv - shared constants, command codes and state encoding for the relay scheduler
package relay_pkg;

    localparam logic [2:0] MOD_MASTER = 3'b000;
    localparam logic [2:0] MOD_SLAVE  = 3'b001;
    localparam logic [2:0] MOD_DELAY  = 3'b010;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_MASTER = 2'b01;
    localparam logic [1:0] OP_SLAVE  = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

    localparam int unsigned REPORT_TICKS = 65552;
    localparam int          CNT_W        = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MASTER_RUN,
        ST_REPORT,
        ST_SLAVE_RUN
    } state_e;

endpackage

// File: rtl/relay_tick_gen.sv
// rtl/relay_tick_gen.sv - free-running divide-by-8 tick generator (1.695 MHz from 13.56 MHz)
module relay_tick_gen (
    input  logic ck_1356meg,
    input  logic rst_n,
    output logic tick
);

    logic [2:0] div_q, div_d;

    always_comb begin
        div_d = div_q + 3'd1;
    end

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 3'd0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == 3'b100);

endmodule

// File: rtl/relay_sched.sv
// rtl/relay_sched.sv - relay window scheduler: master/report/slave windows counted in divider ticks
module relay_sched
    import relay_pkg::*;
#(
    parameter int unsigned REPORT_TICKS_P = REPORT_TICKS
) (
    input  logic        ck_1356meg,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] timeout_cfg,
    input  logic        data_in,
    output logic [2:0]  mod_type,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic        timed_out
);

    localparam logic [CNT_W-1:0] REPORT_LIM = CNT_W'(REPORT_TICKS_P);

    logic             tick;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0]      tmo_q, tmo_d;
    logic [2:0]       sync_q, sync_d;
    logic             done_q, done_d;
    logic             to_q, to_d;
    logic             sync_edge, abort, at_tmo, at_rep;

    relay_tick_gen u_tick (
        .ck_1356meg (ck_1356meg),
        .rst_n      (rst_n),
        .tick       (tick)
    );

    // sync_q[1:0] form the two-flop synchroniser, sync_q[2] is the previous synced value
    assign sync_edge = sync_q[1] & ~sync_q[2];
    assign abort     = cmd_valid && (cmd_op == OP_ABORT);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign at_tmo    = tick && (tmo_q != 16'd0) && (cnt_inc == {1'b0, tmo_q});
    assign at_rep    = tick && (cnt_inc == REPORT_LIM);

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_inc : cnt_q;
        tmo_d   = tmo_q;
        sync_d  = {sync_q[1:0], data_in};
        done_d  = 1'b0;
        to_d    = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (cmd_valid && cmd_op == OP_MASTER) begin
                        state_d = ST_MASTER_RUN;
                        tmo_d   = timeout_cfg;
                    end else if (cmd_valid && cmd_op == OP_SLAVE) begin
                        state_d = ST_SLAVE_RUN;
                        tmo_d   = timeout_cfg;
                    end
                end
                ST_MASTER_RUN: begin
                    // a peer edge beats a coincident timeout
                    if (sync_edge) begin
                        state_d = ST_REPORT;
                        cnt_d   = '0;
                    end else if (at_tmo) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        to_d    = 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (at_rep) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                ST_SLAVE_RUN: begin
                    if (at_tmo) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmo_q   <= 16'd0;
            sync_q  <= 3'd0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            sync_q  <= sync_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        mod_type = MOD_SLAVE;
        case (state_q)
            ST_MASTER_RUN: mod_type = MOD_MASTER;
            ST_REPORT:     mod_type = MOD_DELAY;
            default:       mod_type = MOD_SLAVE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign timed_out = to_q;

endmodule

// File: tb/tb_relay_sched.sv
// tb/tb_relay_sched.sv - randomized scoreboard bench for relay_sched
module tb_relay_sched;
    import relay_pkg::*;

    localparam int R = 37;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] timeout_cfg = 16'd0;
    logic        data_in = 1'b0;
    logic [2:0]  mod_type;
    logic        cmd_ready, busy, done, timed_out;

    int checks = 0;
    int errors = 0;
    int cyc;

    typedef struct {
        bit is_done;
        int at;
    } ev_t;
    ev_t sbq[$];

    relay_sched #(.REPORT_TICKS_P(R)) dut (
        .ck_1356meg  (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .timeout_cfg (timeout_cfg),
        .data_in     (data_in),
        .mod_type    (mod_type),
        .cmd_ready   (cmd_ready),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out)
    );

    always #37 clk = ~clk;

    // cycle n after reset release: divider holds n mod 8, tick when that is 4
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int kth_tick(int s, int k);
        int first;
        first = s + ((12 - (s % 8)) % 8);
        return first + 8 * (k - 1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (done || timed_out)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected pulse: done=%0d timed_out=%0d expected none (cycle %0d)",
                         done, timed_out, cyc);
            end else begin
                ev_t ev;
                ev = sbq.pop_front();
                chk("pulse done", 32'(done), 32'(ev.is_done));
                chk("pulse timed_out", 32'(timed_out), 32'(!ev.is_done));
                chk("pulse cycle", cyc, ev.at);
            end
        end
    end

    task automatic wait_to(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic send(logic [1:0] op, logic [15:0] t);
        cmd_op      = op;
        timeout_cfg = t;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_op      = OP_NOP;
    endtask

    task automatic check_idle(string name);
        chk({name, " mod_type"}, 32'(mod_type), 32'(MOD_SLAVE));
        chk({name, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({name, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_master(int tmo, bit has_edge, int d_off, bit coincide, bit abort_edge, bit rst_mid);
        int a, d, e, tk, fin;
        ev_t ev;
        @(negedge clk);
        a = cyc;
        send(OP_MASTER, 16'(tmo));
        timeout_cfg = 16'($urandom);
        chk("master mod_type", 32'(mod_type), 32'(MOD_MASTER));
        chk("master busy", 32'(busy), 32'd1);
        tk  = (tmo != 0) ? kth_tick(a + 1, tmo) : 32'h3fffffff;
        d   = coincide ? tk - 2 : a + 1 + d_off;
        e   = d + 2;
        fin = tk + 1;
        if (has_edge && e <= tk) begin
            wait_to(d);
            data_in = 1'b1;
            if (abort_edge) begin
                wait_to(e);
                send(OP_ABORT, 16'd0);
                fin = e + 1;
            end else begin
                wait_to(e + 1);
                chk("report mod_type", 32'(mod_type), 32'(MOD_DELAY));
                fin = kth_tick(e + 1, R) + 1;
                if (rst_mid) begin
                    wait_to(e + 10);
                    rst_n = 1'b0;
                    #1;
                    check_idle("mid reset");
                    chk("mid reset done", 32'(done), 32'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    data_in = 1'b0;
                    wait_to(R * 8 + 60);
                    check_idle("after reset");
                    chk("after reset queue", sbq.size(), 0);
                    return;
                end
                ev.is_done = 1'b1;
                ev.at = fin;
                sbq.push_back(ev);
            end
        end else begin
            ev.is_done = 1'b0;
            ev.at = fin;
            sbq.push_back(ev);
        end
        wait_to(fin + 1);
        check_idle("master end");
        chk("master queue empty", sbq.size(), 0);
        data_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_slave(int tmo);
        int a;
        ev_t ev;
        @(negedge clk);
        a = cyc;
        send(OP_SLAVE, 16'(tmo));
        chk("slave mod_type", 32'(mod_type), 32'(MOD_SLAVE));
        chk("slave busy", 32'(busy), 32'd1);
        ev.is_done = 1'b1;
        ev.at = kth_tick(a + 1, tmo) + 1;
        sbq.push_back(ev);
        wait_to(ev.at + 1);
        check_idle("slave end");
        chk("slave queue empty", sbq.size(), 0);
    endtask

    initial begin
        int bad, tmo;
        bit he;
        repeat (2) @(negedge clk);
        check_idle("in reset");
        chk("in reset done", 32'(done), 32'd0);
        chk("in reset timed_out", 32'(timed_out), 32'd0);
        rst_n = 1'b1;

        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (mod_type !== MOD_SLAVE || cmd_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle hold bad cycles", bad, 0);

        send(OP_ABORT, 16'd0);
        check_idle("abort in idle");

        run_master(100, 1'b1, 40 * 8, 1'b0, 1'b0, 1'b0);
        run_master(100, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_master(10, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        run_master(10, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        run_master(1, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        send(OP_SLAVE, 16'd0);
        chk("slave0 busy", 32'(busy), 32'd1);
        repeat (100) @(negedge clk);
        send(OP_MASTER, 16'd5);
        chk("master while busy mod_type", 32'(mod_type), 32'(MOD_SLAVE));
        chk("master while busy busy", 32'(busy), 32'd1);
        repeat (4900) @(negedge clk);
        send(OP_ABORT, 16'd0);
        check_idle("slave abort");
        repeat (2) @(negedge clk);
        chk("slave abort queue", sbq.size(), 0);

        for (int i = 0; i < 12; i++) begin
            tmo = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 40));
            he  = (tmo == 0) ? 1'b1 : 1'($urandom % 2);
            run_master(tmo, he, int'($urandom_range(0, tmo * 8 + 16)), 1'b0,
                       1'($urandom % 4 == 0), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            run_slave(int'($urandom_range(1, 30)));
        end

        run_master(50, 1'b1, 20, 1'b0, 1'b0, 1'b1);
        run_master(3, 1'b1, 2, 1'b0, 1'b0, 1'b0);

        chk("final queue empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
